// File: rtl/modbus_loopback_pkg.sv
// Modbus loopback FIFO shared package.
// Default parameters and frame FSM state encoding.
package modbus_loopback_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_GAP_CYCLES = 35;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/modbus_gap_timer.sv
// Inter-character gap timer and frame FSM.
// Closes a frame after GAP_CYCLES idle cycles.
module modbus_gap_timer
  import modbus_loopback_pkg::*;
#(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_ok,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_frame_len
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  frame_state_t     r_state;
  logic [GW-1:0]    r_gap;
  logic [CNT_W-1:0] r_acc;
  logic             r_done;
  logic [CNT_W-1:0] r_len;

  // Frame FSM: count bytes while active, close frame on a full gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_gap   <= '0;
      r_acc   <= '0;
      r_done  <= 1'b0;
      r_len   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_wr_ok) begin
            r_state <= ACTIVE;
            r_acc   <= {{(CNT_W-1){1'b0}}, 1'b1};
            r_gap   <= '0;
          end
        end
        ACTIVE: begin
          if (i_wr_ok) begin
            if (r_acc != '1)
              r_acc <= r_acc + 1'b1;
            r_gap <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
            if (r_gap == GAP_LAST) begin
              r_done  <= 1'b1;
              r_len   <= r_acc;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_frame_done = r_done;
  assign o_frame_len  = r_len;

endmodule

// File: rtl/modbus_loopback_fifo.sv
// Modbus loopback FIFO with frame gap detection
// and byte/overflow statistics.
module modbus_loopback_fifo
  import modbus_loopback_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tx_enable,
  input  logic [DATA_W-1:0]        tx_data,
  input  logic                     rx_enable,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     frame_done,
  output logic [CNT_W-1:0]         frame_len,
  output logic [CNT_W-1:0]         byte_count,
  output logic [CNT_W-1:0]         overflow_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic [CNT_W-1:0]  r_bytes;
  logic [CNT_W-1:0]  r_ovf;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;
  logic w_wr_drop;

  // Accept decisions use the pre-edge level only.
  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_wr_ok   = tx_enable & ~w_full;
  assign w_rd_ok   = rx_enable & ~w_empty;
  assign w_wr_drop = tx_enable & w_full;

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wptr] <= tx_data;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_ok)
        r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok)
        r_rptr <= r_rptr + 1'b1;
      if (w_wr_ok && !w_rd_ok)
        r_level <= r_level + 1'b1;
      else if (w_rd_ok && !w_wr_ok)
        r_level <= r_level - 1'b1;
    end
  end

  // Registered read port, zero when no read was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_rd_ok;
      r_rx_data  <= w_rd_ok ? r_mem[r_rptr] : '0;
    end
  end

  // Statistics: wrapping byte count, saturating overflow count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bytes <= '0;
      r_ovf   <= '0;
    end else begin
      if (w_wr_ok)
        r_bytes <= r_bytes + 1'b1;
      if (w_wr_drop && r_ovf != '1)
        r_ovf <= r_ovf + 1'b1;
    end
  end

  modbus_gap_timer #(
    .GAP_CYCLES (GAP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_gap (
    .clk          (clk),
    .reset        (reset),
    .i_wr_ok      (w_wr_ok),
    .o_frame_done (frame_done),
    .o_frame_len  (frame_len)
  );

  assign rx_data        = r_rx_data;
  assign rx_valid       = r_rx_valid;
  assign level          = r_level;
  assign byte_count     = r_bytes;
  assign overflow_count = r_ovf;

endmodule

// File: tb/tb_modbus_loopback_fifo.sv
// Bench for modbus_loopback_fifo: directed and random
// traffic against a queue-based reference model.
module tb_modbus_loopback_fifo;

  localparam int DEPTH = 16;
  localparam int GAP   = 35;

  logic clk = 1'b0;
  logic reset;
  logic tx_enable;
  logic [7:0] tx_data;
  logic rx_enable;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [4:0]  level;
  logic        frame_done;
  logic [15:0] frame_len;
  logic [15:0] byte_count;
  logic [15:0] overflow_count;

  logic [7:0] rx_data4;
  logic       rx_valid4;
  logic [4:0] level4;
  logic       frame_done4;
  logic [3:0] frame_len4;
  logic [3:0] byte_count4;
  logic [3:0] overflow_count4;

  always #5 clk = ~clk;

  modbus_loopback_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .tx_enable      (tx_enable),
    .tx_data        (tx_data),
    .rx_enable      (rx_enable),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .level          (level),
    .frame_done     (frame_done),
    .frame_len      (frame_len),
    .byte_count     (byte_count),
    .overflow_count (overflow_count)
  );

  modbus_loopback_fifo #(.CNT_W(4)) dut4 (
    .clk            (clk),
    .reset          (reset),
    .tx_enable      (tx_enable),
    .tx_data        (tx_data),
    .rx_enable      (rx_enable),
    .rx_data        (rx_data4),
    .rx_valid       (rx_valid4),
    .level          (level4),
    .frame_done     (frame_done4),
    .frame_len      (frame_len4),
    .byte_count     (byte_count4),
    .overflow_count (overflow_count4)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] q[$];
  int  m_bytes;
  int  m_ovf;
  bit  in_frame;
  int  cur_len;
  int  idle_run;
  int  exp_len;
  bit  exp_done;
  bit  exp_valid;
  logic [7:0] exp_data;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h t=%0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_bytes   = 0;
    m_ovf     = 0;
    in_frame  = 0;
    cur_len   = 0;
    idle_run  = 0;
    exp_len   = 0;
    exp_done  = 0;
    exp_valid = 0;
    exp_data  = 8'h00;
  endtask

  task automatic compare_all();
    check("rx_valid", 32'(rx_valid), 32'(exp_valid));
    check("rx_data", 32'(rx_data), 32'(exp_data));
    check("level", 32'(level), 32'(q.size()));
    check("frame_done", 32'(frame_done), 32'(exp_done));
    check("frame_len", 32'(frame_len), 32'(sat(exp_len, 65535)));
    check("byte_count", 32'(byte_count), 32'(m_bytes % 65536));
    check("overflow", 32'(overflow_count), 32'(sat(m_ovf, 65535)));
    check("byte_count4", 32'(byte_count4), 32'(m_bytes % 16));
    check("overflow4", 32'(overflow_count4), 32'(sat(m_ovf, 15)));
    check("frame_len4", 32'(frame_len4), 32'(sat(exp_len, 15)));
    check("rx_data4", 32'(rx_data4), 32'(exp_data));
  endtask

  // One clock cycle of stimulus with model update.
  task automatic step(input bit wr,
                      input logic [7:0] d,
                      input bit rd);
    bit rd_ok;
    bit wr_ok;
    tx_enable = wr;
    tx_data   = d;
    rx_enable = rd;
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && (q.size() < DEPTH);
    exp_valid = rd_ok;
    exp_data  = rd_ok ? q.pop_front() : 8'h00;
    if (wr_ok) begin
      q.push_back(d);
      m_bytes++;
    end else if (wr) begin
      m_ovf++;
    end
    exp_done = 0;
    if (wr_ok) begin
      if (!in_frame) begin
        in_frame = 1;
        cur_len  = 1;
      end else begin
        cur_len = sat(cur_len + 1, 65535);
      end
      idle_run = 0;
    end else if (in_frame) begin
      idle_run++;
      if (idle_run == GAP) begin
        exp_done = 1;
        exp_len  = cur_len;
        in_frame = 0;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
    tx_enable = 1'b0;
    rx_enable = 1'b0;
  endtask

  task automatic do_reset();
    tx_enable = 1'b0;
    rx_enable = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    tx_enable = 1'b0;
    rx_enable = 1'b0;
    tx_data   = 8'h00;
    reset     = 1'b1;
    #2;
    do_reset();

    // short write/read sequence
    step(1, 8'h01, 0);
    step(1, 8'h03, 0);
    step(1, 8'h00, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);
    idle(GAP + 2);

    // overflow with 17 writes, then drain
    for (int i = 0; i < 17; i++)
      step(1, 8'(8'h40 + i), 0);
    for (int i = 0; i < 17; i++)
      step(0, 8'h00, 1);
    idle(GAP + 2);

    // full FIFO with simultaneous read and write
    for (int i = 0; i < 16; i++)
      step(1, 8'(8'h80 + i), 0);
    step(1, 8'hEE, 1);
    for (int i = 0; i < 16; i++)
      step(0, 8'h00, 1);
    // empty FIFO with simultaneous read and write
    step(1, 8'h5A, 1);
    step(0, 8'h00, 1);
    idle(GAP + 2);

    // gap of 34 keeps the frame open, then 35 closes it
    for (int i = 0; i < 8; i++)
      step(1, 8'(i), 1);
    idle(GAP - 1);
    for (int i = 0; i < 8; i++)
      step(1, 8'(i + 8), 1);
    idle(GAP);
    idle(3);

    // write landing on the frame_done cycle opens a new frame
    for (int i = 0; i < 3; i++)
      step(1, 8'(i), 1);
    idle(GAP);
    step(1, 8'hA5, 1);
    idle(GAP + 1);

    // reset mid-frame, then a 2-byte frame
    for (int i = 0; i < 5; i++)
      step(1, 8'(8'h10 + i), 0);
    do_reset();
    step(1, 8'h21, 0);
    step(1, 8'h22, 0);
    idle(GAP + 2);
    step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // byte counter wrap and overflow saturation
    do_reset();
    for (int i = 0; i < 17; i++)
      step(1, 8'(i), 1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 16; i++)
      step(1, 8'(i), 0);
    for (int i = 0; i < 20; i++)
      step(1, 8'hFF, 0);
    for (int i = 0; i < 16; i++)
      step(0, 8'h00, 1);
    idle(GAP + 2);

    // randomized traffic
    for (int b = 0; b < 60; b++) begin
      int mode;
      int wp;
      int rp;
      mode = int'($urandom_range(0, 3));
      if (mode == 0) begin
        idle(int'($urandom_range(GAP - 3, GAP + 3)));
      end else begin
        wp = int'($urandom_range(10, 95));
        rp = int'($urandom_range(10, 95));
        for (int i = 0; i < 25; i++)
          step(int'($urandom_range(0, 99)) < wp,
               8'($urandom),
               int'($urandom_range(0, 99)) < rp);
      end
    end
    idle(GAP + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
